// File: rtl/opcode_pkg.sv
// Shared definitions for the opcode sequencer: opcode table, index width and FSM state type.
package opcode_pkg;

    localparam int unsigned NUM_OPCODES = 10;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned OPC_W       = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPCODES - 1);

    localparam logic [OPC_W-1:0] OPCODE_TABLE [NUM_OPCODES] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd14
    };

    typedef enum logic [1:0] {
        SELECT = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        ERROR  = 2'd3
    } state_t;

    // Out-of-range indices map to opcode 0 so the display never shows an unlisted value.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [IDX_W-1:0] idx);
        opcode_of = (idx <= LAST_IDX) ? OPCODE_TABLE[idx] : 4'd0;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rising-edge pulse; the pulse is only armed once the
// synchronized level has been seen low after reset, so a held input yields no event.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic pulse_c
);

    logic       meta;
    logic       level_d;
    logic [1:0] fill;
    logic       armed;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta    <= 1'b0;
            level_o <= 1'b0;
            level_d <= 1'b0;
            fill    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            meta    <= d_i;
            level_o <= meta;
            level_d <= level_o;
            fill    <= {fill[0], 1'b1};
            armed   <= armed | (fill[1] & ~level_o);
        end
    end

    assign pulse_c = level_o & ~level_d & armed;

endmodule

// File: rtl/opcode_sequencer.sv
// Opcode selector: manual/automatic stepping through the valid opcode list,
// launch handshake with the ALU datapath and timeout error recovery.
module opcode_sequencer
    import opcode_pkg::*;
#(
    parameter int unsigned AUTO_PERIOD = 50_000_000,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             next_i,
    input  logic             prev_i,
    input  logic             auto_i,
    input  logic             exec_i,
    input  logic             done_i,
    output logic [OPC_W-1:0] opcode_o,
    output logic             start_o,
    output logic             busy_o,
    output logic             error_o
);

    localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int unsigned TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    logic next_p, prev_p, exec_p, auto_lvl;
    logic next_lvl_unused, prev_lvl_unused, exec_lvl_unused, auto_p_unused;

    sync_edge u_sync_next (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(next_i),
                           .level_o(next_lvl_unused), .pulse_c(next_p));
    sync_edge u_sync_prev (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(prev_i),
                           .level_o(prev_lvl_unused), .pulse_c(prev_p));
    sync_edge u_sync_auto (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(auto_i),
                           .level_o(auto_lvl), .pulse_c(auto_p_unused));
    sync_edge u_sync_exec (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(exec_i),
                           .level_o(exec_lvl_unused), .pulse_c(exec_p));

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt, idx_inc, idx_dec;
    logic [AUTO_W-1:0] auto_cnt, auto_cnt_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;

    assign idx_inc = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    assign idx_dec = (idx == '0) ? LAST_IDX : idx - IDX_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= SELECT;
            idx      <= '0;
            auto_cnt <= '0;
            to_cnt   <= '0;
            opcode_o <= '0;
            start_o  <= 1'b0;
            busy_o   <= 1'b0;
            error_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            auto_cnt <= auto_cnt_nxt;
            to_cnt   <= to_cnt_nxt;
            opcode_o <= opcode_of(idx_nxt);
            start_o  <= (state_nxt == START);
            busy_o   <= (state_nxt == WAIT);
            error_o  <= (state_nxt == ERROR);
        end
    end

    // Next-state logic; exec outranks any index movement while selecting.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        auto_cnt_nxt = auto_cnt;
        to_cnt_nxt   = to_cnt;

        if (!auto_lvl) begin
            auto_cnt_nxt = '0;
        end

        case (state)
            SELECT: begin
                if (exec_p) begin
                    state_nxt = START;
                end else if (auto_lvl) begin
                    if (auto_cnt == AUTO_LAST) begin
                        auto_cnt_nxt = '0;
                        idx_nxt      = idx_inc;
                    end else begin
                        auto_cnt_nxt = auto_cnt + AUTO_W'(1);
                    end
                end else if (next_p && !prev_p) begin
                    idx_nxt = idx_inc;
                end else if (prev_p && !next_p) begin
                    idx_nxt = idx_dec;
                end
            end
            START: begin
                to_cnt_nxt = '0;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (done_i) begin
                    state_nxt = SELECT;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                    if (to_cnt == TO_LAST) begin
                        state_nxt = ERROR;
                    end
                end
            end
            ERROR: begin
                if (exec_p) begin
                    state_nxt = SELECT;
                end
            end
            default: state_nxt = SELECT;
        endcase
    end

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed bench for opcode_sequencer with hand-computed expectations (AUTO_PERIOD=4, TIMEOUT=8).
module tb_opcode_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       next_i, prev_i, auto_i, exec_i, done_i;
    logic [3:0] opcode_o;
    logic       start_o, busy_o, error_o;

    int n_vec  = 0;
    int n_miss = 0;
    int starts;

    logic [3:0] exp_seq [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd14, 4'd0};

    opcode_sequencer #(.AUTO_PERIOD(4), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .next_i(next_i), .prev_i(prev_i),
        .auto_i(auto_i), .exec_i(exec_i), .done_i(done_i), .opcode_o(opcode_o),
        .start_o(start_o), .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold the chosen buttons for 3 cycles (effect lands on the 3rd edge), then release and settle.
    task automatic press(input logic nx, input logic pv, input logic ex);
        next_i = nx;
        prev_i = pv;
        exec_i = ex;
        tick(3);
        next_i = 1'b0;
        prev_i = 1'b0;
        exec_i = 1'b0;
        tick(3);
    endtask

    initial begin
        rst_ni = 1'b0;
        next_i = 1'b0; prev_i = 1'b0; auto_i = 1'b0; exec_i = 1'b0; done_i = 1'b0;
        tick(2);
        chk("rst_opcode", opcode_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_error", error_o, 0);
        #3 rst_ni = 1'b1;
        tick(5);

        // Press latency: unchanged after 2 edges, updated on the 3rd
        next_i = 1'b1;
        tick(2);
        chk("lat_pre", opcode_o, 0);
        tick(1);
        chk("lat_hit", opcode_o, exp_seq[0]);
        next_i = 1'b0;
        tick(3);
        for (int i = 1; i < 10; i++) begin
            press(1'b1, 1'b0, 1'b0);
            chk($sformatf("next_%0d", i), opcode_o, exp_seq[i]);
        end
        press(1'b0, 1'b1, 1'b0);
        chk("prev_wrap", opcode_o, 14);
        press(1'b1, 1'b0, 1'b0);
        chk("next_wrap", opcode_o, 0);
        press(1'b1, 1'b1, 1'b0);
        chk("both_same", opcode_o, 0);

        next_i = 1'b1;
        tick(100);
        next_i = 1'b0;
        tick(3);
        chk("held_once", opcode_o, 1);

        // Automatic stepping every 4 cycles, next ignored meanwhile
        auto_i = 1'b1;
        tick(5);
        chk("auto_pre", opcode_o, 1);
        tick(1);
        chk("auto_1", opcode_o, 2);
        next_i = 1'b1;
        tick(4);
        chk("auto_2", opcode_o, 3);
        tick(4);
        chk("auto_3", opcode_o, 4);
        next_i = 1'b0;
        auto_i = 1'b0;
        tick(20);
        chk("auto_off", opcode_o, 4);
        auto_i = 1'b1;
        tick(5);
        chk("auto_clr_pre", opcode_o, 4);
        tick(1);
        chk("auto_clr_hit", opcode_o, 5);
        auto_i = 1'b0;
        tick(10);
        chk("auto_off2", opcode_o, 5);

        repeat (3) press(1'b1, 1'b0, 1'b0);
        chk("sel_9", opcode_o, 9);

        // Launch and complete
        exec_i = 1'b1;
        tick(2);
        chk("ex_pre_start", start_o, 0);
        tick(1);
        chk("ex_start", start_o, 1);
        chk("ex_start_busy", busy_o, 0);
        tick(1);
        chk("ex_start_once", start_o, 0);
        chk("ex_busy", busy_o, 1);
        chk("ex_opc_held", opcode_o, 9);
        exec_i = 1'b0;
        tick(4);
        chk("ex_busy_wait", busy_o, 1);
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
        chk("ex_done_busy", busy_o, 0);
        chk("ex_done_err", error_o, 0);
        done_i = 1'b1;
        tick(2);
        done_i = 1'b0;
        chk("done_ignored", busy_o, 0);
        press(1'b1, 1'b0, 1'b0);
        chk("back_in_sel", opcode_o, 14);
        press(1'b0, 1'b1, 1'b0);
        chk("back_prev", opcode_o, 9);

        // Timeout after 8 WAIT cycles
        exec_i = 1'b1;
        tick(4);
        exec_i = 1'b0;
        tick(7);
        chk("to_pre_err", error_o, 0);
        chk("to_pre_busy", busy_o, 1);
        tick(1);
        chk("to_err", error_o, 1);
        chk("to_busy", busy_o, 0);
        press(1'b1, 1'b0, 1'b0);
        chk("err_next_ign", opcode_o, 9);
        chk("err_held", error_o, 1);
        press(1'b0, 1'b0, 1'b1);
        chk("err_clear", error_o, 0);

        // done_i on the timeout cycle wins
        exec_i = 1'b1;
        tick(4);
        exec_i = 1'b0;
        tick(7);
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
        chk("to_done_err", error_o, 0);
        chk("to_done_busy", busy_o, 0);
        tick(2);
        chk("to_done_err2", error_o, 0);

        // Asynchronous reset mid-WAIT with exec held through release
        exec_i = 1'b1;
        tick(5);
        chk("rw_busy", busy_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        chk("rw_opcode", opcode_o, 0);
        chk("rw_busy0", busy_o, 0);
        chk("rw_start0", start_o, 0);
        chk("rw_err0", error_o, 0);
        tick(2);
        #3 rst_ni = 1'b1;
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (start_o) starts++;
        end
        chk("rw_no_start", starts, 0);
        chk("rw_busy_after", busy_o, 0);
        chk("rw_opc_after", opcode_o, 0);
        exec_i = 1'b0;
        tick(5);
        press(1'b1, 1'b0, 1'b0);
        chk("post_rst_next", opcode_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
